// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: A - B - Bin computed LSB first through one shared
// full_subtractor cell, with a start/done handshake.

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic diff_out,
    output logic borrow_out
);
    assign diff_out   = x ^ y ^ z;
    assign borrow_out = (~x & y) | (~x & z) | (y & z);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sa, sa_d, sb, sb_d, sd, sd_d, sd_shift, diff_d;
    logic             br, br_d, bout_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             fs_diff, fs_borrow;

    full_subtractor u_fs (
        .x          (sa[0]),
        .y          (sb[0]),
        .z          (br),
        .diff_out   (fs_diff),
        .borrow_out (fs_borrow)
    );

    // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_one
            assign sd_shift = fs_diff;
        end else begin : g_many
            assign sd_shift = {fs_diff, sd[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_d;
            sa    <= sa_d;
            sb    <= sb_d;
            sd    <= sd_d;
            br    <= br_d;
            cnt   <= cnt_d;
            diff  <= diff_d;
            bout  <= bout_d;
        end
    end

    always_comb begin
        state_d = state;
        sa_d    = sa;
        sb_d    = sb;
        sd_d    = sd;
        br_d    = br;
        cnt_d   = cnt;
        diff_d  = diff;
        bout_d  = bout;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    sd_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sd_d  = sd_shift;
                sa_d  = sa >> 1;
                sb_d  = sb >> 1;
                br_d  = fs_borrow;
                cnt_d = cnt + CW'(1);
                // Publish only on the last bit so diff/bout stay stable during RUN.
                if (cnt == LAST) begin
                    diff_d  = sd_shift;
                    bout_d  = fs_borrow;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: a WIDTH=8 instance driven through
// a result scoreboard, and a WIDTH=1 instance checked against the cell truth table.

module tb_serial_subtract_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec8_t;

    typedef struct {
        logic [2:0] abz;
        logic       exp_diff;
        logic       exp_bout;
    } vec1_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       busy1, done1, diff1, bout1;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_seen = 0;

    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtract_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got diff=%h bout=%b, expected no result", diff8, bout8);
            end else begin
                check("result8", {23'b0, bout8, diff8}, {23'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                 input logic [8:0] exp);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_drain();
    endtask

    task automatic checkOutput1(input logic a, input logic b, input logic z,
                                input logic exp_d, input logic exp_b);
        @(posedge clk); #1;
        start1 = 1'b1; a1 = a; b1 = b; bin1 = z;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        @(posedge clk); #1;
        check("w1_done", done1, 1);
        check("w1_result", {bout1, diff1}, {exp_b, exp_d});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec8_t      vecs8[4];
        vec1_t      vecs1[8];
        logic [7:0] ba[4], bb[4];
        logic       bz[4];
        logic [8:0] e;
        int         seen0;

        vecs8[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs8[1] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs8[2] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
        vecs8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        vecs1[0] = '{3'd0, 1'b0, 1'b0};
        vecs1[1] = '{3'd1, 1'b1, 1'b1};
        vecs1[2] = '{3'd2, 1'b1, 1'b1};
        vecs1[3] = '{3'd3, 1'b0, 1'b1};
        vecs1[4] = '{3'd4, 1'b1, 1'b0};
        vecs1[5] = '{3'd5, 1'b0, 1'b0};
        vecs1[6] = '{3'd6, 1'b0, 1'b0};
        vecs1[7] = '{3'd7, 1'b1, 1'b1};

        #2;
        check("reset8_outputs", {busy8, done8, bout8, diff8}, 0);
        check("reset1_outputs", {busy1, done1, bout1, diff1}, 0);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            checkOutput1(vecs1[i].abz[2], vecs1[i].abz[1], vecs1[i].abz[0],
                         vecs1[i].exp_diff, vecs1[i].exp_bout);

        // Cycle-accurate handshake timing for 5A - 3C.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
        sb_q.push_back({1'b0, 8'h1E});
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            check($sformatf("timing_busy_e%0d", k), busy8, (k < 8));
            check($sformatf("timing_done_e%0d", k), done8, (k == 8));
            if (k < 8) check($sformatf("timing_hold_e%0d", k), {bout8, diff8}, 0);
        end
        wait_drain();

        for (int i = 0; i < 4; i++)
            applyStimulus(vecs8[i].a, vecs8[i].b, vecs8[i].bin,
                          {vecs8[i].exp_bout, vecs8[i].exp_diff});

        // Start while busy is ignored; previous FF/1 result stays visible during RUN.
        seen0 = done_seen;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        sb_q.push_back({1'b0, 8'h0F});
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
            else start8 = 1'b0;
            if (k < 8) check($sformatf("busyprot_hold_e%0d", k), {bout8, diff8}, {1'b1, 8'hFF});
        end
        repeat (12) @(posedge clk);
        check("busyprot_single_done", done_seen - seen0, 1);
        check("busyprot_no_pending", sb_q.size(), 0);

        // Back-to-back: start held high, new operands presented in each DONE cycle.
        ba = '{8'h12, 8'h80, 8'h03, 8'hC8};
        bb = '{8'h34, 8'h7F, 8'h03, 8'h19};
        bz = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(posedge clk); #1;
        start8 = 1'b1; a8 = ba[0]; b8 = bb[0]; bin8 = bz[0];
        sb_q.push_back(ref_sub(ba[0], bb[0], bz[0]));
        @(posedge clk); #1;
        for (int n = 1; n <= 4; n++) begin
            repeat (7) @(posedge clk);
            #1;
            check($sformatf("b2b_predone_%0d", n), done8, 0);
            @(posedge clk); #1;
            check($sformatf("b2b_done_%0d", n), done8, 1);
            if (n < 4) begin
                a8 = ba[n]; b8 = bb[n]; bin8 = bz[n];
                sb_q.push_back(ref_sub(ba[n], bb[n], bz[n]));
                @(posedge clk); #1;
                check($sformatf("b2b_rebusy_%0d", n), busy8, 1);
            end else begin
                start8 = 1'b0;
            end
        end
        wait_drain();

        // Asynchronous reset in the middle of RUN discards the operation.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h99; b8 = 8'h11; bin8 = 1'b0;
        sb_q.push_back(ref_sub(8'h99, 8'h11, 1'b0));
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("midreset_outputs", {busy8, done8, bout8, diff8}, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen0 = done_seen;
        repeat (15) @(posedge clk);
        check("midreset_no_done", done_seen - seen0, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rz;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rz = 1'($urandom);
            e = ref_sub(ra, rb, rz);
            applyStimulus(ra, rb, rz, e);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
